// File: rtl/pll_cfg_pkg.sv
// Shared state encoding, field widths and default mode table for the PLL mode sequencer.
// Mode entry layout (LSB first): RATIO0..RATIO[NUM_CH-1], RATIOI, RATIOF, RATIO_W bits each.
package pll_cfg_pkg;

    typedef enum logic [1:0] {
        RST_ASSERT = 2'd0,
        WAIT_LOCK  = 2'd1,
        LOCKED     = 2'd2,
        ERR        = 2'd3
    } state_t;

    localparam int RATIO_W       = 10;
    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_NUM_MODES = 2;

    function automatic int mode_w(input int num_ch);
        return (num_ch + 2) * RATIO_W;
    endfunction

    // Fields 0..num_ch-1 are output ratios, num_ch is RATIOI, num_ch+1 is RATIOF.
    function automatic int field_off(input int num_ch, input int mode, input int field);
        return mode * mode_w(num_ch) + field * RATIO_W;
    endfunction

    // One spare code beyond the last mode so an out-of-range request is encodable.
    function automatic int sel_w(input int num_modes);
        return $clog2(num_modes + 1);
    endfunction

    function automatic int idx_w(input int num_modes);
        return (num_modes > 1) ? $clog2(num_modes) : 1;
    endfunction

    localparam logic [DEF_NUM_MODES*(DEF_NUM_CH+2)*RATIO_W-1:0] DEFAULT_MODE_TABLE = {
        10'd60, 10'd4, 10'd20,  10'd4,
        10'd95, 10'd4, 10'd119, 10'd8
    };

endpackage

// File: rtl/pll_mode_ctrl_if.sv
// Mode-change request handshake between a requester and the PLL mode sequencer.
// A request is taken on any cycle where mode_req_valid and mode_req_ready are both high.
interface pll_mode_ctrl_if
    import pll_cfg_pkg::*;
#(
    parameter int SEL_W = sel_w(DEF_NUM_MODES)
);

    logic             mode_req_valid;
    logic             mode_req_ready;
    logic [SEL_W-1:0] mode_sel;

    modport master (
        output mode_req_valid,
        output mode_sel,
        input  mode_req_ready
    );

    modport slave (
        input  mode_req_valid,
        input  mode_sel,
        output mode_req_ready
    );

endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for the asynchronous PLL lock flag; 2-cycle latency, resets to 0.
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic lock_raw,
    output logic lock_s
);

    logic lock_meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= lock_raw;
            lock_s    <= lock_meta;
        end
    end

endmodule

// File: rtl/pll_mode_ctrl.sv
// Run-time PLL mode sequencer: reset, ratio load, lock wait, lock monitor, bounded retry.
// Ratios/cur_mode update the cycle after an accepted request; optional PLL_MODE_CTRL_GLITCH_GATE_EN gates outputs.
module pll_mode_ctrl
    import pll_cfg_pkg::*;
#(
    parameter int                                     NUM_CH       = DEF_NUM_CH,
    parameter int                                     NUM_MODES    = DEF_NUM_MODES,
    parameter logic [NUM_MODES*mode_w(NUM_CH)-1:0]    MODE_TABLE   = DEFAULT_MODE_TABLE,
    parameter int                                     RST_CYCLES   = 16,
    parameter int                                     LOCK_TIMEOUT = 65536,
    parameter int                                     MAX_RETRY    = 3
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst_n,
    pll_mode_ctrl_if.slave                  req,
    input  logic                            pll_lock_in,
    output logic                            pll_rst,
    output logic                            pll_pwd,
    output logic [RATIO_W-1:0]              ratio_i,
    output logic [RATIO_W-1:0]              ratio_f,
    output logic [NUM_CH*RATIO_W-1:0]       ratio_o,
    output logic [NUM_CH*RATIO_W-1:0]       duty_o,
    output logic [NUM_CH-1:0]               clk_gate,
    output logic [idx_w(NUM_MODES)-1:0]     cur_mode,
    output logic                            locked,
    output logic                            busy,
    output logic                            cfg_err,
    output logic                            pll_err,
    output logic [7:0]                      lost_cnt
);

    localparam int MODE_W  = mode_w(NUM_CH);
    localparam int IDX_W   = idx_w(NUM_MODES);
    localparam int CNT_MAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
    localparam logic [MODE_W-1:0]  MODE0_CFG  = MODE_TABLE[MODE_W-1:0];

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [MODE_W-1:0]    cfg_q, cfg_d;
    logic [IDX_W-1:0]     mode_q, mode_d;
    logic [7:0]           lost_q, lost_d;
    logic                 cfg_err_q, cfg_err_d;

    logic                 lock_s;
    logic                 accept;
    logic                 sel_ok;
    logic [MODE_W-1:0]    sel_cfg;

    pll_lock_sync u_lock_sync (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .lock_raw (pll_lock_in),
        .lock_s   (lock_s)
    );

    assign req.mode_req_ready = (state_q == LOCKED) || (state_q == ERR);
    assign accept             = req.mode_req_valid && req.mode_req_ready;
    assign sel_ok             = int'(req.mode_sel) < NUM_MODES;

    // Mux form keeps the table lookup in range even for an illegal mode_sel.
    always_comb begin
        sel_cfg = MODE0_CFG;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (int'(req.mode_sel) == m) begin
                sel_cfg = MODE_TABLE[m*MODE_W +: MODE_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        cfg_d     = cfg_q;
        mode_d    = mode_q;
        lost_d    = lost_q;
        cfg_err_d = 1'b0;

        unique case (state_q)
            RST_ASSERT: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = LOCKED;
                    cnt_d   = '0;
                    retry_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    cnt_d   = '0;
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = (retry_q == RETRY_LAST) ? ERR : RST_ASSERT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOCKED: begin
                if (!lock_s) begin
                    if (lost_q != 8'hFF) begin
                        lost_d = lost_q + 8'd1;
                    end
                    state_d = RST_ASSERT;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = RST_ASSERT;
                cnt_d   = '0;
            end
        endcase

        // A legal request overrides whatever the lock monitor decided this cycle.
        if (accept) begin
            if (sel_ok) begin
                state_d = RST_ASSERT;
                cnt_d   = '0;
                retry_d = '0;
                cfg_d   = sel_cfg;
                mode_d  = IDX_W'(req.mode_sel);
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= RST_ASSERT;
            cnt_q     <= '0;
            retry_q   <= '0;
            cfg_q     <= MODE0_CFG;
            mode_q    <= '0;
            lost_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            cfg_q     <= cfg_d;
            mode_q    <= mode_d;
            lost_q    <= lost_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign pll_rst  = (state_q == RST_ASSERT) || (state_q == ERR);
    assign pll_pwd  = (state_q == ERR);
    assign pll_err  = (state_q == ERR);
    assign locked   = (state_q == LOCKED);
    assign busy     = (state_q == RST_ASSERT) || (state_q == WAIT_LOCK);
    assign cfg_err  = cfg_err_q;
    assign cur_mode = mode_q;
    assign lost_cnt = lost_q;

    assign ratio_o = cfg_q[NUM_CH*RATIO_W-1:0];
    assign duty_o  = cfg_q[NUM_CH*RATIO_W-1:0];
    assign ratio_i = cfg_q[field_off(NUM_CH, 0, NUM_CH)   +: RATIO_W];
    assign ratio_f = cfg_q[field_off(NUM_CH, 0, NUM_CH+1) +: RATIO_W];

`ifdef PLL_MODE_CTRL_GLITCH_GATE_EN
    localparam logic [6:0] GATE_HOLD = 7'd64;

    logic [6:0] gate_cnt_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gate_cnt_q <= '0;
        end else if (state_q != LOCKED) begin
            gate_cnt_q <= '0;
        end else if (gate_cnt_q != GATE_HOLD) begin
            gate_cnt_q <= gate_cnt_q + 7'd1;
        end
    end

    // Qualified by the current state so the gate closes on the same edge LOCKED is left.
    assign clk_gate = {NUM_CH{(state_q == LOCKED) && (gate_cnt_q == GATE_HOLD)}};
`else
    assign clk_gate = '1;
`endif

endmodule

// File: tb/tb_pll_mode_ctrl.sv
// Directed bench for pll_mode_ctrl with LOCK_TIMEOUT shortened to 100 cycles.
module tb_pll_mode_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lock = 1'b0;

    logic        pll_rst, pll_pwd, locked, busy, cfg_err, pll_err;
    logic [9:0]  ratio_i, ratio_f;
    logic [19:0] ratio_o, duty_o;
    logic [1:0]  clk_gate;
    logic [0:0]  cur_mode;
    logic [7:0]  lost_cnt;

    int checks = 0;
    int passed = 0;

`ifdef PLL_MODE_CTRL_GLITCH_GATE_EN
    localparam logic [1:0] GATE_OFF = 2'b00;
`else
    localparam logic [1:0] GATE_OFF = 2'b11;
`endif
    localparam logic [1:0]  GATE_ON = 2'b11;
    localparam logic [19:0] RO_M0   = {10'd119, 10'd8};
    localparam logic [19:0] RO_M1   = {10'd20, 10'd4};

    always #5 clk = ~clk;

    pll_mode_ctrl_if #(.SEL_W(2)) req_if ();

    pll_mode_ctrl #(
        .NUM_CH(2), .NUM_MODES(2), .RST_CYCLES(16), .LOCK_TIMEOUT(100), .MAX_RETRY(3)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .req(req_if), .pll_lock_in(lock),
        .pll_rst(pll_rst), .pll_pwd(pll_pwd), .ratio_i(ratio_i), .ratio_f(ratio_f),
        .ratio_o(ratio_o), .duty_o(duty_o), .clk_gate(clk_gate), .cur_mode(cur_mode),
        .locked(locked), .busy(busy), .cfg_err(cfg_err), .pll_err(pll_err), .lost_cnt(lost_cnt)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        req_if.mode_req_valid = 1'b0;
        req_if.mode_sel = 2'd0;
        rst_n = 1'b0;
        tick(3);
        checks++; if (pll_rst !== 1'b1) $display("FAIL reset_pll_rst got %0b want 1", pll_rst); else passed++;
        checks++; if (pll_pwd !== 1'b0) $display("FAIL reset_pll_pwd got %0b want 0", pll_pwd); else passed++;
        checks++; if (locked !== 1'b0) $display("FAIL reset_locked got %0b want 0", locked); else passed++;
        checks++; if (ratio_f !== 10'd95) $display("FAIL reset_ratio_f got %0d want 95", ratio_f); else passed++;
        checks++; if (ratio_i !== 10'd4) $display("FAIL reset_ratio_i got %0d want 4", ratio_i); else passed++;
        checks++; if (ratio_o !== RO_M0) $display("FAIL reset_ratio_o got %h want %h", ratio_o, RO_M0); else passed++;
        checks++; if (duty_o !== RO_M0) $display("FAIL reset_duty_o got %h want %h", duty_o, RO_M0); else passed++;
        checks++; if (cur_mode !== 1'b0) $display("FAIL reset_cur_mode got %0d want 0", cur_mode); else passed++;
        checks++; if (lost_cnt !== 8'd0) $display("FAIL reset_lost_cnt got %0d want 0", lost_cnt); else passed++;
        checks++; if ({pll_err, cfg_err} !== 2'b00) $display("FAIL reset_errs got %b want 00", {pll_err, cfg_err}); else passed++;
        checks++; if (req_if.mode_req_ready !== 1'b0) $display("FAIL reset_ready got %0b want 0", req_if.mode_req_ready); else passed++;
    endtask

    task automatic test_power_up;
        rst_n = 1'b1;
        tick(15);
        checks++; if (pll_rst !== 1'b1) $display("FAIL pwrup_rst_c15 got %0b want 1", pll_rst); else passed++;
        tick(1);
        checks++; if (pll_rst !== 1'b0) $display("FAIL pwrup_rst_c16 got %0b want 0", pll_rst); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL pwrup_busy_c16 got %0b want 1", busy); else passed++;
        tick(14);
        lock = 1'b1;
        tick(2);
        checks++; if (locked !== 1'b0) $display("FAIL pwrup_locked_c32 got %0b want 0", locked); else passed++;
        tick(1);
        checks++; if (locked !== 1'b1) $display("FAIL pwrup_locked_c33 got %0b want 1", locked); else passed++;
        checks++; if (req_if.mode_req_ready !== 1'b1) $display("FAIL pwrup_ready got %0b want 1", req_if.mode_req_ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL pwrup_busy_c33 got %0b want 0", busy); else passed++;
    endtask

    task automatic test_gate;
        tick(63);
        checks++; if (clk_gate !== GATE_OFF) $display("FAIL gate_c63 got %b want %b", clk_gate, GATE_OFF); else passed++;
        tick(1);
        checks++; if (clk_gate !== GATE_ON) $display("FAIL gate_c64 got %b want %b", clk_gate, GATE_ON); else passed++;
    endtask

    task automatic test_mode_switch;
        req_if.mode_req_valid = 1'b1;
        req_if.mode_sel = 2'd1;
        tick(1);
        req_if.mode_req_valid = 1'b0;
        checks++; if (ratio_f !== 10'd60) $display("FAIL sw_ratio_f got %0d want 60", ratio_f); else passed++;
        checks++; if (ratio_i !== 10'd4) $display("FAIL sw_ratio_i got %0d want 4", ratio_i); else passed++;
        checks++; if (ratio_o !== RO_M1) $display("FAIL sw_ratio_o got %h want %h", ratio_o, RO_M1); else passed++;
        checks++; if (duty_o !== RO_M1) $display("FAIL sw_duty_o got %h want %h", duty_o, RO_M1); else passed++;
        checks++; if (cur_mode !== 1'b1) $display("FAIL sw_cur_mode got %0d want 1", cur_mode); else passed++;
        checks++; if (pll_rst !== 1'b1) $display("FAIL sw_pll_rst got %0b want 1", pll_rst); else passed++;
        checks++; if (clk_gate !== GATE_OFF) $display("FAIL sw_gate got %b want %b", clk_gate, GATE_OFF); else passed++;
        tick(15);
        checks++; if ({pll_rst, ratio_f} !== {1'b1, 10'd60}) $display("FAIL sw_hold_c15 got %b/%0d want 1/60", pll_rst, ratio_f); else passed++;
        tick(1);
        checks++; if (pll_rst !== 1'b0) $display("FAIL sw_rst_c16 got %0b want 0", pll_rst); else passed++;
        tick(1);
        checks++; if (locked !== 1'b1) $display("FAIL sw_relock got %0b want 1", locked); else passed++;
    endtask

    task automatic test_bad_request;
        req_if.mode_req_valid = 1'b1;
        req_if.mode_sel = 2'd3;
        tick(1);
        req_if.mode_req_valid = 1'b0;
        checks++; if (cfg_err !== 1'b1) $display("FAIL bad_cfg_err got %0b want 1", cfg_err); else passed++;
        checks++; if (cur_mode !== 1'b1) $display("FAIL bad_cur_mode got %0d want 1", cur_mode); else passed++;
        checks++; if ({locked, ratio_f} !== {1'b1, 10'd60}) $display("FAIL bad_held got %b/%0d want 1/60", locked, ratio_f); else passed++;
        tick(1);
        checks++; if (cfg_err !== 1'b0) $display("FAIL bad_pulse_end got %0b want 0", cfg_err); else passed++;
        checks++; if (locked !== 1'b1) $display("FAIL bad_locked_after got %0b want 1", locked); else passed++;
    endtask

    task automatic test_same_mode;
        req_if.mode_req_valid = 1'b1;
        req_if.mode_sel = 2'd1;
        tick(1);
        req_if.mode_req_valid = 1'b0;
        checks++; if ({pll_rst, busy, cur_mode} !== 3'b111) $display("FAIL same_relock got %b want 111", {pll_rst, busy, cur_mode}); else passed++;
        tick(17);
        checks++; if (locked !== 1'b1) $display("FAIL same_locked got %0b want 1", locked); else passed++;
    endtask

    task automatic test_lock_loss;
        lock = 1'b0;
        tick(2);
        checks++; if (locked !== 1'b1) $display("FAIL loss_sync_delay got %0b want 1", locked); else passed++;
        tick(1);
        checks++; if (lost_cnt !== 8'd1) $display("FAIL loss_cnt got %0d want 1", lost_cnt); else passed++;
        checks++; if ({pll_rst, locked} !== 2'b10) $display("FAIL loss_state got %b want 10", {pll_rst, locked}); else passed++;
        tick(2);
        lock = 1'b1;
        tick(14);
        checks++; if ({pll_rst, locked} !== 2'b00) $display("FAIL loss_wait got %b want 00", {pll_rst, locked}); else passed++;
        tick(1);
        checks++; if (locked !== 1'b1) $display("FAIL loss_relock got %0b want 1", locked); else passed++;
    endtask

    task automatic test_req_and_loss;
        lock = 1'b0;
        tick(2);
        req_if.mode_req_valid = 1'b1;
        req_if.mode_sel = 2'd0;
        tick(1);
        req_if.mode_req_valid = 1'b0;
        lock = 1'b1;
        checks++; if (lost_cnt !== 8'd2) $display("FAIL both_lost got %0d want 2", lost_cnt); else passed++;
        checks++; if (cur_mode !== 1'b0) $display("FAIL both_cur_mode got %0d want 0", cur_mode); else passed++;
        checks++; if ({ratio_f, ratio_o} !== {10'd95, RO_M0}) $display("FAIL both_ratios got %0d/%h want 95/%h", ratio_f, ratio_o, RO_M0); else passed++;
        checks++; if ({pll_rst, cfg_err} !== 2'b10) $display("FAIL both_state got %b want 10", {pll_rst, cfg_err}); else passed++;
        tick(17);
        checks++; if (locked !== 1'b1) $display("FAIL both_relock got %0b want 1", locked); else passed++;
    endtask

    task automatic test_lost_saturate;
        for (int i = 0; i < 298; i++) begin
            lock = 1'b0;
            tick(3);
            lock = 1'b1;
            if (i == 251) begin
                checks++; if (lost_cnt !== 8'd254) $display("FAIL sat_254 got %0d want 254", lost_cnt); else passed++;
            end
            if (i == 252) begin
                checks++; if (lost_cnt !== 8'd255) $display("FAIL sat_255 got %0d want 255", lost_cnt); else passed++;
            end
            tick(17);
        end
        checks++; if (lost_cnt !== 8'd255) $display("FAIL sat_300 got %0d want 255", lost_cnt); else passed++;
        checks++; if (locked !== 1'b1) $display("FAIL sat_locked got %0b want 1", locked); else passed++;
    endtask

    task automatic test_timeout;
        int  rises = 0;
        logic prev = 1'b0;
        logic cur;
        lock = 1'b0;
        for (int c = 1; c <= 351; c++) begin
            tick(1);
            cur = busy && pll_rst;
            if (cur && !prev) rises++;
            prev = cur;
            if (c == 350) begin
                checks++; if ({pll_err, busy} !== 2'b01) $display("FAIL to_c350 got %b want 01", {pll_err, busy}); else passed++;
            end
        end
        checks++; if (rises !== 3) $display("FAIL to_reset_phases got %0d want 3", rises); else passed++;
        checks++; if ({pll_err, pll_pwd, pll_rst} !== 3'b111) $display("FAIL to_err got %b want 111", {pll_err, pll_pwd, pll_rst}); else passed++;
        checks++; if ({req_if.mode_req_ready, busy, locked} !== 3'b100) $display("FAIL to_flags got %b want 100", {req_if.mode_req_ready, busy, locked}); else passed++;
        checks++; if (clk_gate !== GATE_OFF) $display("FAIL to_gate got %b want %b", clk_gate, GATE_OFF); else passed++;
    endtask

    task automatic test_err_recovery;
        bit seen = 1'b0;
        req_if.mode_req_valid = 1'b1;
        req_if.mode_sel = 2'd2;
        tick(1);
        req_if.mode_req_valid = 1'b0;
        checks++; if ({cfg_err, pll_err, cur_mode} !== 3'b110) $display("FAIL err_bad got %b want 110", {cfg_err, pll_err, cur_mode}); else passed++;
        req_if.mode_req_valid = 1'b1;
        req_if.mode_sel = 2'd1;
        tick(1);
        req_if.mode_req_valid = 1'b0;
        checks++; if ({pll_err, pll_pwd, pll_rst} !== 3'b001) $display("FAIL err_exit got %b want 001", {pll_err, pll_pwd, pll_rst}); else passed++;
        checks++; if ({cur_mode, ratio_f} !== {1'b1, 10'd60}) $display("FAIL err_mode got %0d/%0d want 1/60", cur_mode, ratio_f); else passed++;
        lock = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick(1);
            seen = locked;
        end
        checks++; if (!seen) $display("FAIL err_relock_timeout got locked=%0b want 1 within 40 cycles", locked); else passed++;
    endtask

    task automatic test_async_reset;
        lock = 1'b0;
        tick(5);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({pll_rst, locked, pll_err} !== 3'b100) $display("FAIL arst_state got %b want 100", {pll_rst, locked, pll_err}); else passed++;
        checks++; if ({cur_mode, ratio_f} !== {1'b0, 10'd95}) $display("FAIL arst_mode got %0d/%0d want 0/95", cur_mode, ratio_f); else passed++;
        checks++; if (lost_cnt !== 8'd0) $display("FAIL arst_lost got %0d want 0", lost_cnt); else passed++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_power_up();
        test_gate();
        test_mode_switch();
        test_bad_request();
        test_same_mode();
        test_lock_loss();
        test_req_and_loss();
        test_lost_saturate();
        test_timeout();
        test_err_recovery();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
